// File: rtl/ulx3s_boot_pkg.sv
// Shared state encoding and counter sizing for the ULX3S boot/exit sequencer.
package ulx3s_boot_pkg;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_RUN    = 2'd1,
    S_DETACH = 2'd2,
    S_PROGN  = 2'd3
  } boot_state_t;

  // One spare bit above $clog2 so the terminal count always fits.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return int'($clog2(cycles)) + 1;
  endfunction

endpackage

// File: rtl/ulx3s_boot_sequencer_btn_debounce.sv
// 2-FF synchronizer plus debounce counter for one raw board button.
module btn_debounce
  import ulx3s_boot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input  logic clk_48mhz,
  input  logic reset_n,
  input  logic btn,
  output logic btn_deb
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A differing level must persist DEBOUNCE_CYCLES cycles to be accepted.
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      sync    <= 2'b00;
      btn_deb <= 1'b0;
      cnt     <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == btn_deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_deb <= ~btn_deb;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ulx3s_boot_sequencer.sv
// Reset stretcher and USB-detach/PROGRAMN exit sequencer around the bootloader.
module ulx3s_boot_sequencer
  import ulx3s_boot_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 32768,
  parameter int unsigned DEBOUNCE_CYCLES = 4096,
  parameter int unsigned DETACH_CYCLES   = 48000
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       clk_ready,
  input  logic       btn_reset,
  input  logic       btn_exit,
  input  logic       boot,
  output logic       bl_reset,
  output logic       usb_se0,
  output logic       user_programn,
  output logic [1:0] state
);

  localparam int unsigned CNT_MAX = (RESET_CYCLES > DETACH_CYCLES) ? RESET_CYCLES : DETACH_CYCLES;
  localparam int unsigned CW      = cnt_width(CNT_MAX);

  logic [1:0]    rdy_sync;
  logic          btn_reset_deb;
  logic          btn_exit_deb;
  logic          rst_cause;
  logic          exit_req;
  boot_state_t   st;
  logic [CW-1:0] cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .btn       (btn_reset),
    .btn_deb   (btn_reset_deb)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .btn       (btn_exit),
    .btn_deb   (btn_exit_deb)
  );

  assign rst_cause = ~rdy_sync[1] | btn_reset_deb;
  assign exit_req  = boot | btn_exit_deb;
  assign state     = st;

  // Outputs are written together with the state so they switch on the entry edge.
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      rdy_sync      <= 2'b00;
      st            <= S_RESET;
      cnt           <= '0;
      bl_reset      <= 1'b1;
      usb_se0       <= 1'b1;
      user_programn <= 1'b1;
    end else begin
      rdy_sync <= {rdy_sync[0], clk_ready};
      case (st)
        S_RESET: begin
          if (rst_cause) begin
            cnt <= '0;
          end else if (cnt == CW'(RESET_CYCLES - 1)) begin
            st       <= S_RUN;
            cnt      <= '0;
            bl_reset <= 1'b0;
            usb_se0  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (rst_cause) begin
            st       <= S_RESET;
            cnt      <= '0;
            bl_reset <= 1'b1;
            usb_se0  <= 1'b1;
          end else if (exit_req) begin
            st      <= S_DETACH;
            cnt     <= '0;
            usb_se0 <= 1'b1;
          end
        end
        S_DETACH: begin
          if (rst_cause) begin
            st       <= S_RESET;
            cnt      <= '0;
            bl_reset <= 1'b1;
          end else if (cnt == CW'(DETACH_CYCLES - 1)) begin
            st            <= S_PROGN;
            cnt           <= '0;
            user_programn <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PROGN: begin
          cnt <= '0;
        end
        default: begin
          st            <= S_RESET;
          cnt           <= '0;
          bl_reset      <= 1'b1;
          usb_se0       <= 1'b1;
          user_programn <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulx3s_boot_sequencer.sv
// Self-checking bench for ulx3s_boot_sequencer with short cycle parameters.
module tb_ulx3s_boot_sequencer;

  logic       clk_48mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       clk_ready = 1'b1;
  logic       btn_reset = 1'b0;
  logic       btn_exit  = 1'b0;
  logic       boot      = 1'b0;
  logic       bl_reset;
  logic       usb_se0;
  logic       user_programn;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       bl;
    logic       se0;
    logic       pn;
  } exp_t;

  typedef struct {
    string      name;
    logic       rdy;
    logic       brst;
    logic       bext;
    logic       bt;
    int         ticks;
    logic [1:0] st;
    logic       bl;
    logic       se0;
    logic       pn;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  ulx3s_boot_sequencer #(
    .RESET_CYCLES    (16),
    .DEBOUNCE_CYCLES (4),
    .DETACH_CYCLES   (8)
  ) dut (
    .clk_48mhz     (clk_48mhz),
    .reset_n       (reset_n),
    .clk_ready     (clk_ready),
    .btn_reset     (btn_reset),
    .btn_exit      (btn_exit),
    .boot          (boot),
    .bl_reset      (bl_reset),
    .usb_se0       (usb_se0),
    .user_programn (user_programn),
    .state         (state)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  function automatic vec_t mk(string name, logic rdy, logic brst, logic bext, logic bt,
                              int ticks, logic [1:0] st, logic bl, logic se0, logic pn);
    vec_t v;
    v.name = name; v.rdy = rdy; v.brst = brst; v.bext = bext; v.bt = bt;
    v.ticks = ticks; v.st = st; v.bl = bl; v.se0 = se0; v.pn = pn;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_48mhz);
  endtask

  task automatic push_exp(input string name, input logic [1:0] st, input logic bl,
                          input logic se0, input logic pn);
    exp_t e;
    e.name = name; e.st = st; e.bl = bl; e.se0 = se0; e.pn = pn;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expectation queued at t=%0t", $time);
    end else begin
      e = sb.pop_front();
      if (state !== e.st || bl_reset !== e.bl || usb_se0 !== e.se0 || user_programn !== e.pn) begin
        errors++;
        $display("FAIL %s: got state=%0d bl_reset=%0b usb_se0=%0b programn=%0b, want state=%0d bl_reset=%0b usb_se0=%0b programn=%0b",
                 e.name, state, bl_reset, usb_se0, user_programn, e.st, e.bl, e.se0, e.pn);
      end
    end
  endtask

  // Queue the expectation, advance n clock edges, then compare at the falling edge.
  task automatic step(input int n, input string name, input logic [1:0] st,
                      input logic bl, input logic se0, input logic pn);
    push_exp(name, st, bl, se0, pn);
    tick(n);
    pop_check();
  endtask

  initial begin
    vecs[0] = mk("pwrup_hold",    1, 0, 0, 0, 17, 2'd0, 1, 1, 1);
    vecs[1] = mk("pwrup_run",     1, 0, 0, 0,  1, 2'd1, 0, 0, 1);
    vecs[2] = mk("rst_rise_wait", 1, 1, 0, 0,  6, 2'd1, 0, 0, 1);
    vecs[3] = mk("rst_rise_enter",1, 0, 0, 0,  1, 2'd0, 1, 1, 1);
    vecs[4] = mk("rst_rel_hold",  1, 0, 0, 0, 20, 2'd0, 1, 1, 1);
    vecs[5] = mk("rst_rel_run",   1, 0, 0, 0,  1, 2'd1, 0, 0, 1);
    vecs[6] = mk("exit_pulse",    1, 0, 0, 1,  1, 2'd2, 0, 1, 1);
    vecs[7] = mk("detach_hold",   1, 0, 0, 0,  7, 2'd2, 0, 1, 1);
    vecs[8] = mk("progn_enter",   1, 0, 0, 0,  1, 2'd3, 0, 1, 0);
    vecs[9] = mk("progn_sticky",  0, 1, 1, 1, 30, 2'd3, 0, 1, 0);

    // Power-up reset held for three edges.
    step(3, "reset_state", 2'd0, 1, 1, 1);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      clk_ready = vecs[i].rdy;
      btn_reset = vecs[i].brst;
      btn_exit  = vecs[i].bext;
      boot      = vecs[i].bt;
      step(vecs[i].ticks, vecs[i].name, vecs[i].st, vecs[i].bl, vecs[i].se0, vecs[i].pn);
      if (i == 1) begin
        // Bouncing reset button must never be accepted.
        for (int j = 0; j < 10; j++) begin
          btn_reset = (j % 2 == 0);
          step(1, "bounce", 2'd1, 0, 0, 1);
        end
        btn_reset = 1'b0;
        step(10, "bounce_settle", 2'd1, 0, 0, 1);
      end
    end

    // Reset in the middle of PROGN.
    clk_ready = 1'b1; btn_reset = 1'b0; btn_exit = 1'b0; boot = 1'b0;
    reset_n = 1'b0;
    step(1, "progn_reset", 2'd0, 1, 1, 1);
    reset_n = 1'b1;
    step(17, "rerun_hold", 2'd0, 1, 1, 1);
    step(1, "rerun_run", 2'd1, 0, 0, 1);

    // Abort DETACH by losing PLL lock at count 3.
    boot = 1'b1;
    step(1, "abort_enter", 2'd2, 0, 1, 1);
    boot = 1'b0;
    step(3, "abort_cnt3", 2'd2, 0, 1, 1);
    clk_ready = 1'b0;
    step(2, "abort_sync", 2'd2, 0, 1, 1);
    step(1, "abort_reset", 2'd0, 1, 1, 1);
    clk_ready = 1'b1;
    step(17, "abort_rec_hold", 2'd0, 1, 1, 1);
    step(1, "abort_rec_run", 2'd1, 0, 0, 1);

    // Debounced reset and boot land on the same cycle: reset wins.
    btn_reset = 1'b1;
    step(6, "simul_pre", 2'd1, 0, 0, 1);
    boot = 1'b1;
    step(1, "simul_reset", 2'd0, 1, 1, 1);
    boot = 1'b0;
    for (int j = 0; j < 10; j++) step(1, "simul_no_detach", 2'd0, 1, 1, 1);
    btn_reset = 1'b0;
    step(21, "simul_rel_hold", 2'd0, 1, 1, 1);
    step(1, "simul_rel_run", 2'd1, 0, 0, 1);

    // Exit via debounced button.
    btn_exit = 1'b1;
    step(6, "bexit_wait", 2'd1, 0, 0, 1);
    step(1, "bexit_detach", 2'd2, 0, 1, 1);
    btn_exit = 1'b0;
    step(8, "bexit_progn", 2'd3, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
